register_dump: RTL and testbench

Debug readout engine for the register file: on a start request it walks all 32 architectural registers through a read port and streams each one out as a 5-byte frame over a byte-wide valid/ready interface. It sits between the register file's debug read port and the board UART transmitter, so register contents can be inspected on a host while the core runs. It is the reader counterpart of the register-file write path: it only ever reads, never writes.

---
 rtl/register_dump_pkg.sv | 17 +
 rtl/register_dump.sv | 110 +++++++++++
 tb/tb_register_dump.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_dump_pkg.sv
// register_dump_pkg: shared definitions for the register dump engine.
//   - state_e     : FSM state encoding (2-bit)
//   - FRAME_BYTES : bytes per register frame (index byte + 4 data bytes)
//   - IDX_PAD     : upper padding of the index byte (index is zero-extended)
package register_dump_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StSend = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned FRAME_BYTES = 5;
  localparam logic [7:0]  IDX_PAD     = 8'h00;

endpackage

// File: rtl/register_dump.sv
// register_dump: debug readout engine. On i_start it walks registers 0..NUM_REGS-1 through a
// combinational read port and streams each as a 5-byte frame (index, data[31:24] .. data[7:0])
// over a byte-wide valid/ready interface.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_start           : dump request, honoured only in idle
//   o_busy            : high from the cycle after start acceptance until back in idle
//   o_done            : one-cycle pulse after the last byte of the last register
//   o_rd_addr         : register index to the register file read port
//   i_rd_data         : read data for o_rd_addr, same cycle
//   o_tx_data         : current byte
//   o_tx_valid        : o_tx_data is valid
//   i_tx_ready        : sink accepts the byte (transfer when valid & ready at a rising edge)
module register_dump
  import register_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready
);

  localparam int unsigned ShiftW = 8 + DATA_W;

  state_e              r_state;
  logic [ShiftW-1:0]   r_shift;
  logic [2:0]          r_byte_cnt;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_tx_valid;

  logic                w_xfer;
  logic                w_last_byte;
  logic                w_last_reg;
  logic [7:0]          w_idx_byte;

  assign w_xfer      = r_tx_valid & i_tx_ready;
  assign w_last_byte = (r_byte_cnt == 3'(FRAME_BYTES - 1));
  assign w_last_reg  = (r_rd_addr == ADDR_W'(NUM_REGS - 1));
  assign w_idx_byte  = IDX_PAD | 8'(r_rd_addr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_rd_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_rd_addr <= '0;
            r_busy    <= 1'b1;
            r_state   <= StLoad;
          end
        end
        StLoad: begin
          // Register contents are captured here only; later writes do not reach this frame.
          r_shift    <= {w_idx_byte, i_rd_data};
          r_byte_cnt <= '0;
          r_tx_valid <= 1'b1;
          r_state    <= StSend;
        end
        StSend: begin
          if (w_xfer) begin
            if (!w_last_byte) begin
              r_shift    <= {r_shift[ShiftW-9:0], 8'h00};
              r_byte_cnt <= r_byte_cnt + 3'd1;
            end else if (w_last_reg) begin
              r_tx_valid <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= StDone;
            end else begin
              r_tx_valid <= 1'b0;
              r_rd_addr  <= r_rd_addr + ADDR_W'(1);
              r_state    <= StLoad;
            end
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rd_addr  = r_rd_addr;
  assign o_tx_data  = r_shift[ShiftW-1 -: 8];
  assign o_tx_valid = r_tx_valid;

endmodule

// File: tb/tb_register_dump.sv
// tb_register_dump: directed, scoreboard-based bench for register_dump. A small register file
// model drives rd_data; each accepted start pushes the expected 160 bytes, and every transfer
// pops and compares. Outputs are sampled and inputs driven on the falling edge.
module tb_register_dump;

  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        tx_valid;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic [31:0] regs [NR];

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  register_dump #(
    .NUM_REGS(NR),
    .ADDR_W  (5),
    .DATA_W  (32)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .o_busy    (busy),
    .o_done    (done),
    .o_rd_addr (rd_addr),
    .i_rd_data (rd_data),
    .o_tx_data (tx_data),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         last_done_cyc = -1;
  bit         rnd_ready = 1'b0;
  bit         start_req = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] ref_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected byte stream of one full dump from the current register model.
  task automatic push_dump();
    for (int r = 0; r < NR; r++) begin
      exp_q.push_back(8'(r));
      exp_q.push_back(regs[r][31:24]);
      exp_q.push_back(regs[r][23:16]);
      exp_q.push_back(regs[r][15:8]);
      exp_q.push_back(regs[r][7:0]);
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    if (prev_stall) begin
      check("stall_valid", 64'(tx_valid), 64'd1);
      check("stall_data", 64'(tx_data), 64'(prev_data));
    end
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    start     = start_req;
    start_req = 1'b0;
    tx_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (tx_valid && tx_ready) begin
      rx_q.push_back(tx_data);
      n_vec++;
      assert (exp_q.size() != 0)
      else begin
        n_err++;
        $error("FAIL unexpected_byte: observed %02h expected no byte", tx_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tx_byte", 64'(tx_data), 64'(e));
      end
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
  endtask

  task automatic pulse_start();
    start_req = 1'b1;
    tick();
  endtask

  task automatic run_until_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    n_vec++;
    assert (done_cnt != d0)
    else begin
      n_err++;
      $error("FAIL done_timeout: observed no done within %0d cycles, expected a done pulse", budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int d0;
    int mism;
    logic [7:0] f1 [5];
    logic [7:0] f31 [5];

    f1  = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    f31 = '{8'h1F, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < NR; i++) regs[i] = 32'h0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(tx_valid), 64'd0);
    check("rst_data", 64'(tx_data), 64'd0);
    check("rst_addr", 64'(rd_addr), 64'd0);
    rst = 1'b0;
    tick();
    regs[1]  = 32'h1234_5678;
    regs[31] = 32'hDEAD_BEEF;

    // Full dump, tx_ready held high
    push_dump();
    rx_q.delete();
    pulse_start();
    s = cyc;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 1) begin
        check("t1_busy_load", 64'(busy), 64'd1);
        check("t1_valid_load", 64'(tx_valid), 64'd0);
      end
      if (k == 2) begin
        check("t1_valid_first", 64'(tx_valid), 64'd1);
        check("t1_first_byte", 64'(tx_data), 64'h00);
      end
      if (k == 193) check("t1_busy_done", 64'(busy), 64'd1);
      if (k == 194) check("t1_busy_fall", 64'(busy), 64'd0);
    end
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_done_cyc", 64'(last_done_cyc - s), 64'd193);
    check("t1_bytes", 64'(rx_q.size()), 64'd160);
    check("t1_leftover", 64'(exp_q.size()), 64'd0);
    if (rx_q.size() == 160) begin
      for (int i = 0; i < 5; i++) begin
        check("t1_frame1", 64'(rx_q[5 + i]), 64'(f1[i]));
        check("t1_frame31", 64'(rx_q[155 + i]), 64'(f31[i]));
      end
    end
    ref_q = rx_q;

    // Random back-pressure: same byte sequence, stable during stalls
    rnd_ready = 1'b1;
    push_dump();
    rx_q.delete();
    pulse_start();
    run_until_done(3000);
    rnd_ready = 1'b0;
    repeat (3) tick();
    check("t2_bytes", 64'(rx_q.size()), 64'd160);
    mism = 0;
    for (int i = 0; i < 160 && i < rx_q.size(); i++) if (rx_q[i] !== ref_q[i]) mism++;
    check("t2_vs_nostall", 64'(mism), 64'd0);

    // Start during the 3rd frame is ignored
    d0 = done_cnt;
    push_dump();
    rx_q.delete();
    pulse_start();
    repeat (14) tick();
    start_req = 1'b1;
    tick();
    tick();
    check("t3_busy", 64'(busy), 64'd1);
    run_until_done(400);
    repeat (20) tick();
    check("t3_done_once", 64'(done_cnt - d0), 64'd1);
    check("t3_bytes", 64'(rx_q.size()), 64'd160);
    check("t3_idle", 64'(busy), 64'd0);

    // Reset during SEND of register 10
    push_dump();
    rx_q.delete();
    pulse_start();
    repeat (63) tick();
    check("t4_addr10", 64'(rd_addr), 64'd10);
    check("t4_sending", 64'(tx_valid), 64'd1);
    rst = 1'b1;
    tick();
    check("t4_valid", 64'(tx_valid), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_addr", 64'(rd_addr), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
    d0 = done_cnt;
    repeat (10) tick();
    check("t4_no_done", 64'(done_cnt), 64'(d0));
    push_dump();
    rx_q.delete();
    pulse_start();
    run_until_done(400);
    check("t4_restart_bytes", 64'(rx_q.size()), 64'd160);
    if (rx_q.size() != 0) check("t4_restart_idx0", 64'(rx_q[0]), 64'h00);

    // Rewrite R5 while frame 5 is being sent
    push_dump();
    rx_q.delete();
    pulse_start();
    repeat (33) tick();
    check("t5_addr5", 64'(rd_addr), 64'd5);
    regs[5] = 32'hCAFE_F00D;
    run_until_done(400);
    check("t5_bytes", 64'(rx_q.size()), 64'd160);
    if (rx_q.size() == 160)
      check("t5_frame5", {24'h0, rx_q[25], rx_q[26], rx_q[27], rx_q[28], rx_q[29]},
            64'h05_0000_0000);

    // Start in the first idle cycle after done
    push_dump();
    rx_q.delete();
    pulse_start();
    s = cyc;
    tick();
    check("t6_busy", 64'(busy), 64'd1);
    run_until_done(400);
    check("t6_done_cyc", 64'(last_done_cyc - s), 64'd193);
    check("t6_bytes", 64'(rx_q.size()), 64'd160);
    if (rx_q.size() == 160)
      check("t6_frame5", {24'h0, rx_q[25], rx_q[26], rx_q[27], rx_q[28], rx_q[29]},
            64'h05_CAFE_F00D);
    repeat (3) tick();
    check("t6_leftover", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
